// File: rtl/hpdcache_downsize_arb.sv
// Round-robin arbiter feeding a shared wide-to-narrow downsize buffer.
// Grants are held for a whole burst; beats are emitted as RD_WIDTH words with source/ID tags.
module hpdcache_downsize_arb #(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned WR_WIDTH = 256,
    parameter int unsigned RD_WIDTH = 64,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned ID_WIDTH = 4,
    localparam int unsigned RD_WORDS = WR_WIDTH / RD_WIDTH,
    localparam int unsigned SRC_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned WORD_W   = (RD_WORDS > 1) ? $clog2(RD_WORDS) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_REQ-1:0]             req_valid_i,
    output logic [N_REQ-1:0]             req_ready_o,
    input  logic [N_REQ*WR_WIDTH-1:0]    req_data_i,
    input  logic [N_REQ*ID_WIDTH-1:0]    req_id_i,
    input  logic [N_REQ-1:0]             req_last_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [RD_WIDTH-1:0]          rsp_data_o,
    output logic [SRC_W-1:0]             rsp_src_o,
    output logic [ID_WIDTH-1:0]          rsp_id_o,
    output logic [WORD_W-1:0]            rsp_word_o,
    output logic                         rsp_beat_last_o,
    output logic                         rsp_last_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e              state_q, state_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]    lock_src_q, lock_src_d;
    logic [SRC_W-1:0]    grant_src;
    logic                grant_vld;
    int unsigned         scan_idx;
    logic [SRC_W-1:0]    scan_src;

    logic [N_REQ-1:0][WR_WIDTH-1:0] req_data_arr;
    logic [N_REQ-1:0][ID_WIDTH-1:0] req_id_arr;

    logic [WR_WIDTH-1:0] data_q [DEPTH];
    logic [SRC_W-1:0]    src_q  [DEPTH];
    logic [ID_WIDTH-1:0] id_q   [DEPTH];
    logic [DEPTH-1:0]    last_q;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    used_q;
    logic [WORD_W-1:0]   cnt_q;

    logic                buf_full, buf_empty;
    logic                push, push_last, pop, word_end;
    logic [RD_WORDS-1:0][RD_WIDTH-1:0] cur_words;

    function automatic logic [SRC_W-1:0] src_inc(input logic [SRC_W-1:0] s);
        return (s == SRC_W'(N_REQ - 1)) ? '0 : s + SRC_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign req_data_arr = req_data_i;
    assign req_id_arr   = req_id_i;

    // Arbitration: upward scan from rr_ptr in IDLE, fixed lock in LOCKED
    always_comb begin
        grant_vld = 1'b0;
        grant_src = '0;
        scan_idx  = 0;
        scan_src  = '0;
        if (state_q == LOCKED) begin
            grant_src = lock_src_q;
            grant_vld = req_valid_i[lock_src_q];
        end else begin
            for (int unsigned off = 0; off < N_REQ; off++) begin
                scan_idx = (32'(rr_ptr_q) + off) % N_REQ;
                scan_src = SRC_W'(scan_idx);
                if (!grant_vld && req_valid_i[scan_src]) begin
                    grant_vld = 1'b1;
                    grant_src = scan_src;
                end
            end
        end
    end

    assign push      = grant_vld & ~buf_full;
    assign push_last = req_last_i[grant_src];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_src_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_src_q <= lock_src_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_src_d = lock_src_q;
        if (push) begin
            case (state_q)
                IDLE: begin
                    if (push_last) begin
                        rr_ptr_d = src_inc(grant_src);
                    end else begin
                        state_d    = LOCKED;
                        lock_src_d = grant_src;
                    end
                end
                LOCKED: begin
                    if (push_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = src_inc(lock_src_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready_o = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ready_o[i] = grant_vld && (grant_src == SRC_W'(i)) && !buf_full;
        end
    end

    // Shared data/tag FIFO: one pointer pair, pop only on the final word of a beat
    assign buf_full  = (used_q == CNT_W'(DEPTH));
    assign buf_empty = (used_q == '0);
    assign word_end  = (cnt_q == WORD_W'(RD_WORDS - 1));
    assign pop       = rsp_valid_o & rsp_ready_i & word_end;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                src_q[i]  <= '0;
                id_q[i]   <= '0;
            end
            last_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= req_data_arr[grant_src];
                src_q[wr_ptr_q]  <= grant_src;
                id_q[wr_ptr_q]   <= req_id_arr[grant_src];
                last_q[wr_ptr_q] <= push_last;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   used_q <= used_q + CNT_W'(1);
                2'b01:   used_q <= used_q - CNT_W'(1);
                default: used_q <= used_q;
            endcase
            if (rsp_valid_o && rsp_ready_i) begin
                cnt_q <= word_end ? '0 : cnt_q + WORD_W'(1);
            end
        end
    end

    assign cur_words       = data_q[rd_ptr_q];
    assign rsp_valid_o     = ~buf_empty;
    assign rsp_data_o      = cur_words[cnt_q];
    assign rsp_src_o       = src_q[rd_ptr_q];
    assign rsp_id_o        = id_q[rd_ptr_q];
    assign rsp_word_o      = cnt_q;
    assign rsp_beat_last_o = rsp_valid_o & word_end;
    assign rsp_last_o      = rsp_beat_last_o & last_q[rd_ptr_q];

endmodule

// File: tb/tb_hpdcache_downsize_arb.sv
// Table-driven bench for hpdcache_downsize_arb (N_REQ=2, 256->64, DEPTH=2).
// Lane k of a beat with base nibble b is sixteen copies of nibble (b+k).
module tb_hpdcache_downsize_arb;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [1:0]   req_valid_i = '0;
    logic [1:0]   req_ready_o;
    logic [511:0] req_data_i = '0;
    logic [7:0]   req_id_i = '0;
    logic [1:0]   req_last_i = '0;
    logic         rsp_valid_o;
    logic         rsp_ready_i = 1'b0;
    logic [63:0]  rsp_data_o;
    logic         rsp_src_o;
    logic [3:0]   rsp_id_o;
    logic [1:0]   rsp_word_o;
    logic         rsp_beat_last_o;
    logic         rsp_last_o;

    int n_tests = 0;
    int n_fail  = 0;

    hpdcache_downsize_arb #(
        .N_REQ    (2),
        .WR_WIDTH (256),
        .RD_WIDTH (64),
        .DEPTH    (2),
        .ID_WIDTH (4)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_data_i      (req_data_i),
        .req_id_i        (req_id_i),
        .req_last_i      (req_last_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_data_o      (rsp_data_o),
        .rsp_src_o       (rsp_src_o),
        .rsp_id_o        (rsp_id_o),
        .rsp_word_o      (rsp_word_o),
        .rsp_beat_last_o (rsp_beat_last_o),
        .rsp_last_o      (rsp_last_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst;
        logic [1:0] valid;
        logic [1:0] last;
        logic [3:0] b0, b1, i0, i1;
        logic       rdy;
        logic [1:0] er;
        logic       ev;
        logic [3:0] en;
        logic       es;
        logic [3:0] ei;
        logic [1:0] ew;
        logic       ebl, el;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input int r, v, l, b0, b1, i0, i1, rd,
                                 input int er, ev, en, es, ei, ew, ebl, el);
        vec_t x;
        x.rst = 1'(r);   x.valid = 2'(v); x.last = 2'(l);
        x.b0 = 4'(b0);   x.b1 = 4'(b1);   x.i0 = 4'(i0); x.i1 = 4'(i1);
        x.rdy = 1'(rd);  x.er = 2'(er);   x.ev = 1'(ev); x.en = 4'(en);
        x.es = 1'(es);   x.ei = 4'(ei);   x.ew = 2'(ew);
        x.ebl = 1'(ebl); x.el = 1'(el);
        return x;
    endfunction

    function automatic logic [255:0] beat(input logic [3:0] b);
        logic [255:0] r;
        logic [3:0]   nib;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            nib = b + 4'(k);
            r[k*64 +: 64] = {16{nib}};
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        req_valid_i = '0;
        req_last_i  = '0;
        rsp_ready_i = 1'b0;
        rst_ni      = 1'b0;
        @(negedge clk_i);
        rst_ni      = 1'b1;
    endtask

    task automatic check_all_reset(input string name);
        check({name, " ctrl"}, {124'd0, req_ready_o, rsp_valid_o, rsp_beat_last_o},
              128'd0 | {rsp_last_o, 1'b0} & 128'd0);
        check({name, " last"}, {127'd0, rsp_last_o}, 128'd0);
        check({name, " data"}, {57'd0, rsp_data_o, rsp_src_o, rsp_id_o, rsp_word_o}, 128'd0);
    endtask

    initial begin
        // Scenario A: single 1-beat burst from source 0, id 5
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 1, 1, 0, 0, 5, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 5, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 5, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 2, 0, 5, 2, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 3, 0, 5, 3, 1, 1));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0));
        // Scenario B: both sources valid, 1-beat bursts, grants alternate 0,1,0,1
        tbl.push_back(mkv(1, 3, 3, 0, 8, 1, 2, 1,  1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 3, 3, 0, 8, 1, 2, 1,  2, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 3, 3, 0, 8, 1, 2, 1,  0, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mkv(0, 3, 3, 0, 8, 1, 2, 1,  0, 1, 2, 0, 1, 2, 0, 0));
        tbl.push_back(mkv(0, 3, 3, 0, 8, 1, 2, 1,  0, 1, 3, 0, 1, 3, 1, 1));
        tbl.push_back(mkv(0, 3, 3, 0, 8, 1, 2, 1,  1, 1, 8, 1, 2, 0, 0, 0));
        tbl.push_back(mkv(0, 3, 3, 0, 8, 1, 2, 1,  0, 1, 9, 1, 2, 1, 0, 0));
        tbl.push_back(mkv(0, 3, 3, 0, 8, 1, 2, 1,  0, 1, 10, 1, 2, 2, 0, 0));
        tbl.push_back(mkv(0, 3, 3, 0, 8, 1, 2, 1,  0, 1, 11, 1, 2, 3, 1, 1));
        tbl.push_back(mkv(0, 3, 3, 0, 8, 1, 2, 1,  2, 1, 0, 0, 1, 0, 0, 0));
        // Scenario C: source 1 3-beat burst (bases 4,8,C) with source 0 waiting
        tbl.push_back(mkv(1, 2, 0, 0, 4, 3, 7, 1,  2, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 3, 0, 0, 8, 3, 7, 1,  2, 1, 4, 1, 7, 0, 0, 0));
        tbl.push_back(mkv(0, 3, 3, 0, 12, 3, 7, 1, 0, 1, 5, 1, 7, 1, 0, 0));
        tbl.push_back(mkv(0, 3, 3, 0, 12, 3, 7, 1, 0, 1, 6, 1, 7, 2, 0, 0));
        tbl.push_back(mkv(0, 3, 3, 0, 12, 3, 7, 1, 0, 1, 7, 1, 7, 3, 1, 0));
        tbl.push_back(mkv(0, 1, 3, 0, 12, 3, 7, 1, 0, 1, 8, 1, 7, 0, 0, 0));
        tbl.push_back(mkv(0, 3, 3, 0, 12, 3, 7, 1, 2, 1, 9, 1, 7, 1, 0, 0));
        tbl.push_back(mkv(0, 1, 3, 0, 12, 3, 7, 1, 0, 1, 10, 1, 7, 2, 0, 0));
        tbl.push_back(mkv(0, 1, 3, 0, 12, 3, 7, 1, 0, 1, 11, 1, 7, 3, 1, 0));
        tbl.push_back(mkv(0, 1, 3, 0, 12, 3, 7, 1, 1, 1, 12, 1, 7, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 13, 1, 7, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 14, 1, 7, 2, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 15, 1, 7, 3, 1, 1));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 3, 0, 0, 0));
        // Scenario D: buffer fills with rsp_ready low, drains in order
        tbl.push_back(mkv(1, 3, 3, 0, 8, 1, 2, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 3, 3, 0, 8, 1, 2, 0,  2, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 3, 3, 0, 8, 1, 2, 0,  0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 3, 3, 0, 8, 1, 2, 1,  0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 3, 3, 0, 8, 1, 2, 1,  0, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mkv(0, 3, 3, 0, 8, 1, 2, 1,  0, 1, 2, 0, 1, 2, 0, 0));
        tbl.push_back(mkv(0, 3, 3, 0, 8, 1, 2, 1,  0, 1, 3, 0, 1, 3, 1, 1));
        tbl.push_back(mkv(0, 3, 3, 0, 8, 1, 2, 1,  1, 1, 8, 1, 2, 0, 0, 0));
        // Scenario E: rsp_ready toggles every cycle
        tbl.push_back(mkv(1, 1, 1, 0, 0, 5, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 5, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 5, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 5, 1, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 2, 0, 5, 2, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 2, 0, 5, 2, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 3, 0, 5, 3, 1, 1));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 3, 0, 5, 3, 1, 1));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));

        // Reset state with all inputs idle
        do_reset();
        @(negedge clk_i);
        #1;
        check_all_reset("reset");

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            @(negedge clk_i);
            req_valid_i = tbl[i].valid;
            req_last_i  = tbl[i].last;
            req_data_i  = {beat(tbl[i].b1), beat(tbl[i].b0)};
            req_id_i    = {tbl[i].i1, tbl[i].i0};
            rsp_ready_i = tbl[i].rdy;
            #1;
            check($sformatf("vec%0d ctrl", i),
                  {123'd0, req_ready_o, rsp_valid_o, rsp_beat_last_o, rsp_last_o},
                  {123'd0, tbl[i].er, tbl[i].ev, tbl[i].ebl, tbl[i].el});
            if (tbl[i].ev) begin
                check($sformatf("vec%0d data", i),
                      {57'd0, rsp_data_o, rsp_src_o, rsp_id_o, rsp_word_o},
                      {57'd0, {16{tbl[i].en}}, tbl[i].es, tbl[i].ei, tbl[i].ew});
            end
        end

        // Reset asserted while locked on source 1 with word 2 of beat 1 pending
        do_reset();
        @(negedge clk_i);
        req_valid_i = 2'b10; req_last_i = 2'b00; rsp_ready_i = 1'b1;
        req_data_i  = {beat(4'h4), beat(4'h0)}; req_id_i = 8'h70;
        @(negedge clk_i);
        req_data_i  = {beat(4'h8), beat(4'h0)};
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        check("midbeat word2", {126'd0, rsp_word_o}, 128'd2);
        req_valid_i = 2'b00;
        rst_ni      = 1'b0;
        #1;
        check_all_reset("midbeat rst");
        @(negedge clk_i);
        rst_ni      = 1'b1;
        req_valid_i = 2'b11; req_last_i = 2'b11;
        #1;
        check("post-rst grant", {125'd0, req_ready_o, rsp_valid_o}, {125'd0, 2'b01, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hpdcache_downsize_arb.md
# hpdcache_downsize_arb

Round-robin arbiter and sequencer that shares one wide-to-narrow data downsize buffer between N_REQ refill/response sources. Each source delivers bursts of WR_WIDTH-bit beats tagged with an ID; the block grants one source at a time, holds the grant until the burst ends, and pushes every accepted beat into an internal downsize FIFO. On the narrow side it emits RD_WIDTH-bit words together with the source index, ID, word index and last-word flags, ready for the cache data-array write port.

## Interface
- N_REQ, default 2: number of requesters; must be at least 2.
- WR_WIDTH, default 256: beat width in bits; must be a multiple of RD_WIDTH.
- RD_WIDTH, default 64: output word width in bits; RD_WORDS = WR_WIDTH/RD_WIDTH, and RD_WORDS must be at least 2.
- DEPTH, default 2: beat entries in the data buffer and in the tag FIFO; must be at least 1.
- ID_WIDTH, default 4: width of the transaction ID.
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  N_REQ  per-source beat valid.
- req_ready_o  out  N_REQ  per-source beat accept; a beat transfers when valid and ready are both high.
- req_data_i  in  N_REQ x WR_WIDTH  per-source beat data.
- req_id_i  in  N_REQ x ID_WIDTH  per-source ID.
- req_last_i  in  N_REQ  marks the last beat of a burst.
- rsp_valid_o  out  1  output word valid.
- rsp_ready_i  in  1  output word accept.
- rsp_data_o  out  RD_WIDTH  output word; word 0 is bits [RD_WIDTH-1:0] of the beat.
- rsp_src_o  out  max(1,$clog2(N_REQ))  index of the source that supplied the beat.
- rsp_id_o  out  ID_WIDTH  ID captured with the beat.
- rsp_word_o  out  max(1,$clog2(RD_WORDS))  word index within the beat, 0 to RD_WORDS-1.
- rsp_beat_last_o  out  1  high on the last word of a beat.
- rsp_last_o  out  1  high on the last word of the last beat of a burst.

## Operation
- FSM with two states, IDLE and LOCKED.
  - IDLE: grant the first valid source found searching upward from rr_ptr, wrapping modulo N_REQ.
  - LOCKED: grant only lock_src.
- req_ready_o[i] = grant[i] & ~buf_full. req_ready_o may depend combinationally on req_valid_i.
- Accepting a beat pushes req_data_i into the data buffer. The same cycle pushes {src, id, last} into the tag FIFO. Both FIFOs use the same depth and the same pointers.
- IDLE transitions:
  - Accepted beat with last=0: go to LOCKED and set lock_src to the granted source.
  - Accepted beat with last=1: stay in IDLE and set rr_ptr to src+1 mod N_REQ.
- LOCKED transitions:
  - Accepted beat with last=1: go to IDLE and set rr_ptr to lock_src+1 mod N_REQ.
  - If the locked source drops valid mid-burst, the lock is kept and all other sources see ready=0.
- Output side:
  - rsp_valid_o = ~buf_empty.
  - A word counter starts at 0. On each word handshake it increments; on the last word of a beat it returns to 0 and pops both FIFOs.
  - rsp_word_o = counter.
  - rsp_beat_last_o = rsp_valid_o & (counter == RD_WORDS-1).
  - rsp_last_o = rsp_beat_last_o & tag.last.
- Full and empty:
  - buf_full means used == DEPTH. buf_empty means used == 0.
  - No bypass: a beat push and the final-word pop of a different beat may occur in the same cycle, and used is then unchanged.
  - When full, req_ready_o is low even if a pop happens in that cycle.
- Pointers wrap from DEPTH-1 to 0, and DEPTH need not be a power of two.
- used has $clog2(DEPTH)+1 bits.

## Timing
- Reset values: state=IDLE, rr_ptr=0, lock_src=0, pointers=0, used=0, counter=0, buffer contents=0.
- Output values after reset:
  - rsp_valid_o, rsp_beat_last_o and rsp_last_o are 0.
  - rsp_word_o, rsp_src_o and rsp_id_o are 0.
  - req_ready_o is 0 whenever req_valid_i is 0.
- Latency: a beat accepted at edge T drives rsp_valid_o high with word 0 after T, with no bubble.
- Throughput is one word per cycle. With DEPTH ≥ 2 and rsp_ready_i held high, one source streams back-to-back, one beat every RD_WORDS cycles.
- Output stability:
  - rsp_* is registered state, or muxes of registered state.
  - While rsp_valid_o=1 and rsp_ready_i=0, all rsp_* outputs hold stable.
- An asserted rst_ni at any cycle, including mid-burst or mid-beat, immediately clears the lock, the FIFOs and the counter.
  - Partially emitted beats are discarded.
  - The first grant after release starts searching from source 0.

## Test plan
- Default parameters, source 0 sends a 1-beat burst with data 0x3333_..._2222_..._1111_..._0000 (64-bit lanes), id=5, last=1, and rsp_ready_i=1.
  - Expect 4 words 0x0..0, 0x1..1, 0x2..2, 0x3..3 with src=0, id=5 and word 0 to 3.
  - Expect beat_last and last on word 3.
  - The first word is valid the cycle after acceptance.
- Both sources continuously valid with 1-beat bursts.
  - Grants alternate 0,1,0,1.
  - rsp_src_o follows the same sequence.
- Source 1 sends a 3-beat burst while source 0 is valid throughout.
  - Source 0 sees ready=0 until source 1's last beat is accepted, then source 0 is granted next.
  - rsp_last_o is high only on word 3 of beat 3.
- DEPTH=2 with rsp_ready_i=0.
  - Two beats are accepted, then req_ready_o=0.
  - Raise rsp_ready_i: ready returns on the cycle after the 4th word pops, and no data is lost or reordered.
- Backpressure: toggle rsp_ready_i every cycle.
  - rsp_* stays stable while stalled.
  - Words are emitted in order 0 to 3.
- Assert rst_ni low while in LOCKED mid-beat (word 2 pending).
  - All outputs read reset values.
  - After release, with both sources valid, source 0 is granted first.
